// File: rtl/layer21_train_ctrl_pkg.sv
// rtl/layer21_train_ctrl_pkg.sv - shared types, FSM encodings and target helper for layer21_train_ctrl
// Optional build macro: SOFT_TARGET_EN (soft targets instead of hard one-hot).
package layer21_train_ctrl_pkg;

    typedef logic [7:0] zero2one_t;
    typedef logic [4:0] class_idx_t;
    typedef logic [2:0] train_state_t;

    localparam zero2one_t ZERO2ONE_MAX = 8'hFF;

    localparam train_state_t ST_IDLE    = 3'd0;
    localparam train_state_t ST_PRESENT = 3'd1;
    localparam train_state_t ST_DECIDE  = 3'd2;
    localparam train_state_t ST_LEARN   = 3'd3;
    localparam train_state_t ST_REPORT  = 3'd4;

    // Out-of-range labels produce an all-zero target in both builds.
    function automatic zero2one_t target_value(input logic hit, input logic label_ok);
`ifdef SOFT_TARGET_EN
        if (!label_ok)
            return '0;
        return hit ? zero2one_t'(ZERO2ONE_MAX - (ZERO2ONE_MAX >> 3)) : zero2one_t'(ZERO2ONE_MAX >> 3);
`else
        return (hit && label_ok) ? ZERO2ONE_MAX : '0;
`endif
    endfunction

endpackage

// File: rtl/layer21_train_ctrl_if.sv
// rtl/layer21_train_ctrl_if.sv - sample, layer and result signals of layer21_train_ctrl
// master = controller side, slave = sample source / layer / result sink side.
interface layer21_train_ctrl_if
    import layer21_train_ctrl_pkg::*;
#(
    parameter int N       = 16,
    parameter int CLASSES = 21
);
    logic                       s_valid;
    logic                       s_ready;
    zero2one_t [N-1:0]          s_in;
    class_idx_t                 s_label;
    logic                       s_train;

    logic                       layer_valid;
    logic                       layer_learn;
    zero2one_t [N-1:0]          layer_in;
    zero2one_t [CLASSES-1:0]    layer_out;
    zero2one_t [CLASSES-1:0]    layer_expected_out;

    logic                       r_valid;
    logic                       r_ready;
    class_idx_t                 r_class;
    logic                       r_correct;

    modport master (
        input  s_valid, s_in, s_label, s_train, layer_out, r_ready,
        output s_ready, layer_valid, layer_learn, layer_in, layer_expected_out,
               r_valid, r_class, r_correct
    );

    modport slave (
        output s_valid, s_in, s_label, s_train, layer_out, r_ready,
        input  s_ready, layer_valid, layer_learn, layer_in, layer_expected_out,
               r_valid, r_class, r_correct
    );
endinterface

// File: rtl/layer21_train_ctrl_argmax.sv
// rtl/layer21_train_ctrl_argmax.sv - zero2one_argmax: combinational argmax tree, lowest index wins ties
// Leaves are padded to a power of two; padding leaves are marked invalid and never win.
module zero2one_argmax
    import layer21_train_ctrl_pkg::*;
#(
    parameter int N  = 21,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  zero2one_t [N-1:0] in_i,
    output logic [IW-1:0]     idx_o
);
    localparam int P = 1 << $clog2(N);

    zero2one_t      leaf_val [P];
    logic           leaf_vld [P];
    zero2one_t      node_val [2*P];
    logic [IW-1:0]  node_idx [2*P];
    logic           node_vld [2*P];

    for (genvar g = 0; g < P; g++) begin : g_leaf
        if (g < N) begin : g_real
            assign leaf_val[g] = in_i[g];
            assign leaf_vld[g] = 1'b1;
        end else begin : g_pad
            assign leaf_val[g] = '0;
            assign leaf_vld[g] = 1'b0;
        end
    end

    // Heap layout: node i has children 2i (lower indices) and 2i+1; the right child
    // only wins on a strictly greater value, which gives lowest-index tie breaking.
    always_comb begin
        for (int i = 0; i < 2*P; i++) begin
            node_val[i] = '0;
            node_idx[i] = '0;
            node_vld[i] = 1'b0;
        end
        for (int i = 0; i < P; i++) begin
            node_val[P+i] = leaf_val[i];
            node_idx[P+i] = IW'(i);
            node_vld[P+i] = leaf_vld[i];
        end
        for (int i = P - 1; i >= 1; i--) begin
            if (node_vld[2*i+1] && (!node_vld[2*i] || (node_val[2*i+1] > node_val[2*i]))) begin
                node_val[i] = node_val[2*i+1];
                node_idx[i] = node_idx[2*i+1];
            end else begin
                node_val[i] = node_val[2*i];
                node_idx[i] = node_idx[2*i];
            end
            node_vld[i] = node_vld[2*i] | node_vld[2*i+1];
        end
        idx_o = node_idx[1];
    end
endmodule

// File: rtl/layer21_train_ctrl.sv
// rtl/layer21_train_ctrl.sv - sample sequencer around the learning layer: present, argmax, learn, report
// SOFT_TARGET_EN (see package) selects soft targets; FSM and latency are identical in both builds.
module layer21_train_ctrl
    import layer21_train_ctrl_pkg::*;
#(
    parameter int N       = 16,
    parameter int CLASSES = 21,
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    layer21_train_ctrl_if.master bus,
    input  logic               clear_stats,
    output logic [CNT_W-1:0]   cnt_samples,
    output logic [CNT_W-1:0]   cnt_correct
);
    localparam int         AIW         = (CLASSES > 1) ? $clog2(CLASSES) : 1;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    train_state_t             state_q, state_d;
    logic [3:0]               settle_q, settle_d;
    zero2one_t [N-1:0]        layer_in_q, layer_in_d;
    zero2one_t [CLASSES-1:0]  exp_q, exp_d;
    class_idx_t               label_q, label_d;
    logic                     train_q, train_d;
    class_idx_t               r_class_q, r_class_d;
    logic                     r_correct_q, r_correct_d;
    logic [CNT_W-1:0]         cnt_s_q, cnt_s_d;
    logic [CNT_W-1:0]         cnt_c_q, cnt_c_d;

    logic [AIW-1:0]           argmax_idx;
    class_idx_t               argmax_class;
    logic                     s_label_ok;
    logic                     label_ok_q;

    zero2one_argmax #(.N(CLASSES)) u_argmax (
        .in_i  (bus.layer_out),
        .idx_o (argmax_idx)
    );

    assign argmax_class = class_idx_t'(argmax_idx);
    assign s_label_ok   = 32'(bus.s_label) < 32'(CLASSES);
    assign label_ok_q   = 32'(label_q) < 32'(CLASSES);

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        layer_in_d  = layer_in_q;
        exp_d       = exp_q;
        label_d     = label_q;
        train_d     = train_q;
        r_class_d   = r_class_q;
        r_correct_d = r_correct_q;
        cnt_s_d     = cnt_s_q;
        cnt_c_d     = cnt_c_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.s_valid) begin
                    layer_in_d = bus.s_in;
                    label_d    = bus.s_label;
                    train_d    = bus.s_train;
                    for (int c = 0; c < CLASSES; c++)
                        exp_d[c] = target_value(bus.s_label == class_idx_t'(c), s_label_ok);
                    settle_d   = SETTLE_LOAD;
                    state_d    = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (settle_q == 4'd0)
                    state_d = ST_DECIDE;
                else
                    settle_d = settle_q - 4'd1;
            end
            ST_DECIDE: begin
                r_class_d   = argmax_class;
                r_correct_d = (argmax_class == label_q) && label_ok_q;
                state_d     = ST_LEARN;
            end
            ST_LEARN: begin
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (bus.r_ready) begin
                    if (cnt_s_q != '1)
                        cnt_s_d = cnt_s_q + 1'b1;
                    if (r_correct_q && (cnt_c_q != '1))
                        cnt_c_d = cnt_c_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear in the same cycle as a report handshake discards that increment.
        if (clear_stats) begin
            cnt_s_d = '0;
            cnt_c_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            layer_in_q  <= '0;
            exp_q       <= '0;
            label_q     <= '0;
            train_q     <= 1'b0;
            r_class_q   <= '0;
            r_correct_q <= 1'b0;
            cnt_s_q     <= '0;
            cnt_c_q     <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            layer_in_q  <= layer_in_d;
            exp_q       <= exp_d;
            label_q     <= label_d;
            train_q     <= train_d;
            r_class_q   <= r_class_d;
            r_correct_q <= r_correct_d;
            cnt_s_q     <= cnt_s_d;
            cnt_c_q     <= cnt_c_d;
        end
    end

    // Decoded from the state register so the async reset kills learn/valid immediately.
    assign bus.s_ready            = (state_q == ST_IDLE);
    assign bus.layer_valid        = (state_q == ST_PRESENT) || (state_q == ST_DECIDE) || (state_q == ST_LEARN);
    assign bus.layer_learn        = (state_q == ST_LEARN) && train_q && label_ok_q;
    assign bus.layer_in           = layer_in_q;
    assign bus.layer_expected_out = exp_q;
    assign bus.r_valid            = (state_q == ST_REPORT);
    assign bus.r_class            = r_class_q;
    assign bus.r_correct          = r_correct_q;
    assign cnt_samples            = cnt_s_q;
    assign cnt_correct            = cnt_c_q;
endmodule
